// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared widths, constants and helpers for the fetch stage.
//               The opcode constants are also used by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    // The jump index is already a word address, so it replaces the low bits
    // of PC+1 directly with no shift.
    function automatic logic [WORD_W-1:0] make_jump_addr(
        input logic [WORD_W-1:0] pc_plus1,
        input logic [JIDX_W-1:0] jump_index
    );
        return {pc_plus1[WORD_W-1:JIDX_W], jump_index};
    endfunction

endpackage : instruction_fetch_unit_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Instruction-memory bus, redirect controls from later stages
//               and the IF/ID register outputs of the fetch unit.
//   master : fetch unit (drives pc_out, ifid_*, fetch_fault)
//   slave  : memory / pipeline side (drives ins_in, stall, flush, redirects)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    // Instruction memory bus
    logic [WORD_W-1:0] pc_out;
    logic [WORD_W-1:0] ins_in;

    // Control from later pipeline stages
    logic              stall;
    logic              flush;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_target;
    logic              jump;
    logic [JIDX_W-1:0] jump_index;

    // IF/ID pipeline register and status
    logic [WORD_W-1:0] ifid_ins;
    logic [WORD_W-1:0] ifid_pc_plus1;
    logic              ifid_valid;
    logic              fetch_fault;

    modport master (
        output pc_out,
        input  ins_in,
        input  stall,
        input  flush,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_index,
        output ifid_ins,
        output ifid_pc_plus1,
        output ifid_valid,
        output fetch_fault
    );

    modport slave (
        input  pc_out,
        output ins_in,
        output stall,
        output flush,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_index,
        input  ifid_ins,
        input  ifid_pc_plus1,
        input  ifid_valid,
        input  fetch_fault
    );

endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC selector.
//   i_pc            current PC (word address)
//   i_branch_taken  branch resolved taken, i_branch_target its word address
//   i_jump          J-type jump decoded, i_jump_index instruction bits [25:0]
//   i_stall         hold the PC
//   o_next_pc       PC to load at the next edge
//   o_pc_plus1      i_pc + 1 (wraps modulo 2^32)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
    import instruction_fetch_unit_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_pc,
    input  wire logic              i_branch_taken,
    input  wire logic [WORD_W-1:0] i_branch_target,
    input  wire logic              i_jump,
    input  wire logic [JIDX_W-1:0] i_jump_index,
    input  wire logic              i_stall,
    output logic      [WORD_W-1:0] o_next_pc,
    output logic      [WORD_W-1:0] o_pc_plus1
);

    logic [WORD_W-1:0] w_pc_plus1;
    logic [WORD_W-1:0] w_jump_addr;

    assign w_pc_plus1  = i_pc + 32'd1;
    assign w_jump_addr = make_jump_addr(w_pc_plus1, i_jump_index);
    assign o_pc_plus1  = w_pc_plus1;

    // The branch is the older instruction, so it wins over a jump in the
    // same cycle; both redirects override a stall. Flush never moves the PC
    // differently from the normal path, so it is not an input here.
    always_comb begin
        o_next_pc = w_pc_plus1;
        if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end else if (i_jump) begin
            o_next_pc = w_jump_addr;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end
    end

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. Owns the PC, presents it to instruction memory,
//               captures the returned word into the IF/ID register and
//               applies stall, flush and branch/jump redirects.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : instruction_fetch_unit_if.master - memory bus, pipeline controls,
//          IF/ID outputs and sticky fetch_fault
// Parameters:
//   RESET_PC  : word address loaded into the PC on reset
//   MEM_DEPTH : number of words in instruction memory (valid 0..MEM_DEPTH-1)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 10240
) (
    input  wire logic                clk,
    input  wire logic                rst,
    instruction_fetch_unit_if.master bus
);

    // One extra bit so a depth of 2^32 would still compare correctly.
    localparam logic [WORD_W:0] c_mem_depth = (WORD_W+1)'(MEM_DEPTH);

    logic [WORD_W-1:0] pc_q,            pc_d;
    logic [WORD_W-1:0] ifid_ins_q,      ifid_ins_d;
    logic [WORD_W-1:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic              ifid_valid_q,    ifid_valid_d;
    logic              fetch_fault_q,   fetch_fault_d;

    logic [WORD_W-1:0] w_pc_plus1;
    logic              w_in_range;
    logic [WORD_W-1:0] w_fetch_word;

    fetch_next_pc u_fetch_next_pc (
        .i_pc            (pc_q),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .i_jump          (bus.jump),
        .i_jump_index    (bus.jump_index),
        .i_stall         (bus.stall),
        .o_next_pc       (pc_d),
        .o_pc_plus1      (w_pc_plus1)
    );

    assign w_in_range   = ({1'b0, pc_q} < c_mem_depth);
    // Out-of-range reads return whatever the memory drives; never let that
    // reach decode.
    assign w_fetch_word = w_in_range ? bus.ins_in : NOP_WORD;

    always_comb begin
        ifid_ins_d      = ifid_ins_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_fault_d   = fetch_fault_q;

        if (bus.branch_taken || bus.jump || (!bus.stall && bus.flush)) begin
            // Redirect or flush: the word fetched this cycle is wrong-path.
            ifid_ins_d      = NOP_WORD;
            ifid_pc_plus1_d = '0;
            ifid_valid_d    = 1'b0;
        end else if (!bus.stall) begin
            ifid_ins_d      = w_fetch_word;
            ifid_pc_plus1_d = w_pc_plus1;
            ifid_valid_d    = w_in_range;
            if (!w_in_range) begin
                fetch_fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            ifid_ins_q      <= NOP_WORD;
            ifid_pc_plus1_q <= '0;
            ifid_valid_q    <= 1'b0;
            fetch_fault_q   <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_ins_q      <= ifid_ins_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_fault_q   <= fetch_fault_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.ifid_ins      = ifid_ins_q;
    assign bus.ifid_pc_plus1 = ifid_pc_plus1_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.fetch_fault   = fetch_fault_q;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction memory interface: owns the PC, drives the word address to the instruction memory and captures the returned word.
- Holds the IF/ID pipeline register: instruction, PC+1 and a valid bit.
- Applies stall, flush and branch/jump redirects from later stages; flags fetches outside the memory range.

Parameters:
- RESET_PC, 0: word address loaded into the PC on reset.
- MEM_DEPTH, 10240: number of 32-bit words in the instruction memory; valid fetch addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_out  out  32  current PC = word address to instruction memory (word index, not byte address).
- ins_in  in  32  instruction word from memory; combinational, valid in the same cycle as pc_out.
- stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- flush  in  1  squash IF/ID contents at next edge; PC still advances.
- branch_taken  in  1  branch resolved taken.
- branch_target  in  32  full word-address branch target.
- jump  in  1  J-type jump decoded.
- jump_index  in  26  instruction bits [25:0].
- ifid_ins  out  32  registered instruction.
- ifid_pc_plus1  out  32  registered PC+1 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky: a fetch was attempted at PC >= MEM_DEPTH.

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - PC=RESET_PC, ifid_ins=0 (NOP), ifid_pc_plus1=0, ifid_valid=0, fetch_fault=0.
  - Reset asserted mid-stall or mid-redirect discards the pending action.
- pc_plus1 = PC+1, modulo 2^32; wrap from 0xFFFFFFFF to 0 is allowed (that fetch is already faulted).
- jump_addr = {pc_plus1[31:26], jump_index}. Jump index is a word address, so no shift is applied.
- in_range = (PC < MEM_DEPTH). fetch_word = ins_in when in_range, else 0.
- Priority per edge, highest first: rst > branch_taken > jump > stall > flush > normal.
  - branch_taken: PC<=branch_target; IF/ID<=bubble. The branch is the older instruction, so it beats a simultaneous jump, and it overrides stall.
  - jump: PC<=jump_addr; IF/ID<=bubble; overrides stall.
  - stall: PC, ifid_ins, ifid_pc_plus1 and ifid_valid all hold; fetch_fault is not updated.
  - flush (no redirect, no stall): PC<=pc_plus1; IF/ID<=bubble.
  - normal: PC<=pc_plus1; ifid_ins<=fetch_word; ifid_pc_plus1<=pc_plus1; ifid_valid<=in_range.
- Bubble = ifid_ins=0, ifid_pc_plus1=0, ifid_valid=0.
- fetch_fault is set on any normal-path edge with in_range=0 and cleared only by rst. The PC keeps advancing after a fault; no halt.
- Latency:
  - Word at PC appears on ifid_ins one edge after PC is presented.
  - Redirect penalty: exactly one bubble cycle, then the target word one edge after that.
- No combinational path from stall/flush/branch inputs to pc_out; pc_out is a register output.

Decomposition:
- Shared package:
  - NOP_WORD = 32'h0
  - WORD_W = 32
  - JIDX_W = 26
  - opcode constants OP_J = 6'b000010 and OP_BEQ = 6'b000100, shared with the decode stage
- One combinational sub-module, fetch_next_pc: inputs pc, branch/jump controls and targets, stall; output next PC.
- Keeps the priority mux separate from the register block and lets it be unit-tested alone.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: memory with mem[0]=32'h8C010384, mem[1]=32'h8C020385; release rst.
  - Cycle 0: pc_out=0.
  - Edge 1: ifid_ins=8C010384, ifid_pc_plus1=1, valid=1, pc_out=1.
  - Edge 2: ifid_ins=8C020385, pc_out=2.
- Jump:
  - Stimulus: at PC=13 (IF/ID holds mem[12]=32'h08000005), decode asserts jump with jump_index=5.
  - Next edge: pc_out=5, ifid_valid=0.
  - Following edge: ifid_ins=mem[5]=32'h00610820, ifid_pc_plus1=6.
- Stall then release:
  - Stimulus: stall=1 for 2 cycles at PC=7; release stall.
  - Response: pc_out stays 7 and ifid_ins is unchanged for both cycles; after release, PC advances to 8 on the next edge.
- Simultaneous events:
  - branch_taken=1 (target 19), jump=1 (target 5), stall=1 in the same cycle -> pc_out=19, bubble.
  - flush=1 alone at PC=4 -> pc_out=5, ifid_valid=0.
- Range fault with MEM_DEPTH=16:
  - Stimulus: branch to 15, then run 2 cycles.
  - Fetch at PC=15: valid=1. Fetch at PC=16: ifid_ins=0, valid=0, fetch_fault=1; fault stays 1 until rst.
- Reset mid-redirect:
  - Stimulus: assert rst in the same cycle as branch_taken (target 40).
  - Response: pc_out=RESET_PC, all IF/ID fields 0, fetch_fault=0.
